// File: rtl/uart_pkg.sv
// Shared types and field positions for the UART Avalon host.
// The host's optional TX/RX transfer counters are compiled in when
// UART_AVALON_HOST_CNT_EN is defined.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } host_state_t;

  localparam int ADW_DEFAULT      = 32;
  localparam int BYTESIZE_DEFAULT = 8;

  // Readdata bit that mirrors the UART core's interrupt line
  function automatic int irqBit(input int adw);
    return adw - 1;
  endfunction

  // Readdata bit the UART core raises when a received character was overwritten
  function automatic int errBit(input int adw);
    return adw - 2;
  endfunction

  // Readdata bit holding the received character's parity
  function automatic int parBit(input int bytesize);
    return bytesize;
  endfunction

  // One RX FIFO entry is the character plus its parity bit
  function automatic int entryWidth(input int bytesize);
    return bytesize + 1;
  endfunction

endpackage

// File: rtl/uart_avalon_host_fifo.sv
// Small synchronous FIFO that buffers characters drained from the UART core.
// Pointers wrap naturally because DEPTH is a power of two; a separate
// DLOG+1 bit occupancy count tells full from empty.
module uart_avalon_host_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  parameter int DLOG  = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_headData,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [DLOG:0]   FULL_COUNT = (DLOG+1)'(DEPTH);
  localparam logic [DLOG-1:0] PTR_ONE    = DLOG'(1);
  localparam logic [DLOG:0]   CNT_ONE    = (DLOG+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DLOG-1:0]  r_wptr;
  logic [DLOG-1:0]  r_rptr;
  logic [DLOG:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full     = (r_count == FULL_COUNT);
  assign o_empty    = (r_count == '0);
  assign w_doPush   = i_push & ~o_full;
  assign w_doPop    = i_pop & ~o_empty;
  assign o_headData = r_mem[r_rptr];

  // Storage array; contents need no reset since the count guards every read
  always_ff @(posedge i_clk) begin
    if (w_doPush) begin
      r_mem[r_wptr] <= i_pushData;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count alone
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_doPop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_avalon_host.sv
// Avalon-MM initiator for the UART core's register port: turns a TX byte
// stream into writes and drains received characters into a local FIFO
// whenever the core's interrupt is raised.
// Define UART_AVALON_HOST_CNT_EN to add 16-bit completed-write/read counters.
module uart_avalon_host
  import uart_pkg::*;
#(
  parameter int ADW      = ADW_DEFAULT,
  parameter int BYTESIZE = BYTESIZE_DEFAULT,
  parameter int DEPTH    = 4,
  parameter int DLOG     = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_tx_valid,
  input  logic [BYTESIZE-1:0] i_tx_data,
  output logic                o_tx_ready,
  output logic                o_rx_valid,
  output logic [BYTESIZE-1:0] o_rx_data,
  output logic                o_rx_par,
  input  logic                i_rx_ready,
  input  logic                i_uart_irq,
  output logic                o_avm_read,
  output logic                o_avm_write,
  output logic [ADW-1:0]      o_avm_writedata,
  input  logic [ADW-1:0]      i_avm_readdata,
  input  logic                i_avm_waitrequest,
  output logic                o_ovf,
  input  logic                i_ovf_clr
`ifdef UART_AVALON_HOST_CNT_EN
  ,
  output logic [15:0]         o_cnt_tx,
  output logic [15:0]         o_cnt_rx
`endif
);

  localparam int ERR_BIT = errBit(ADW);
  localparam int PAR_BIT = parBit(BYTESIZE);
  localparam int EW      = entryWidth(BYTESIZE);

  host_state_t       r_state;
  logic              r_avm_read;
  logic              r_avm_write;
  logic [ADW-1:0]    r_avm_writedata;
  logic              r_ovf;
  logic              w_full;
  logic              w_empty;
  logic              w_rdCond;
  logic              w_rdDone;
  logic              w_wrDone;
  logic              w_pop;
  logic [EW-1:0]     w_pushData;
  logic [EW-1:0]     w_headData;
  logic              w_unusedRd;

  // A read is only started when there is room to keep the character; otherwise it waits in the core
  assign w_rdCond   = i_uart_irq & ~w_full;
  assign o_tx_ready = (r_state == IDLE) & ~w_rdCond & i_tx_valid & ~i_rst;
  assign w_rdDone   = (r_state == RD) & ~i_avm_waitrequest;
  assign w_wrDone   = (r_state == WR) & ~i_avm_waitrequest;
  assign w_pushData = {i_avm_readdata[PAR_BIT], i_avm_readdata[BYTESIZE-1:0]};
  assign w_pop      = i_rx_ready & ~w_empty;
  assign w_unusedRd = ^i_avm_readdata;

  assign o_avm_read      = r_avm_read;
  assign o_avm_write     = r_avm_write;
  assign o_avm_writedata = r_avm_writedata;
  assign o_ovf           = r_ovf;
  assign o_rx_valid      = ~w_empty;
  assign o_rx_data       = w_headData[BYTESIZE-1:0];
  assign o_rx_par        = w_headData[BYTESIZE];

  // Transfer sequencer; every transfer returns through IDLE so the core's irq clear is seen before re-arbitration
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_avm_read      <= 1'b0;
      r_avm_write     <= 1'b0;
      r_avm_writedata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rdCond) begin
            r_state    <= RD;
            r_avm_read <= 1'b1;
          end else if (i_tx_valid) begin
            r_state         <= WR;
            r_avm_write     <= 1'b1;
            r_avm_writedata <= ADW'(i_tx_data);
          end
        end
        RD: begin
          if (!i_avm_waitrequest) begin
            r_state    <= IDLE;
            r_avm_read <= 1'b0;
          end
        end
        WR: begin
          if (!i_avm_waitrequest) begin
            r_state     <= IDLE;
            r_avm_write <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_avm_read  <= 1'b0;
          r_avm_write <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun flag; a new overrun in the same cycle as a clear keeps it set
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
    end else if (w_rdDone && i_avm_readdata[ERR_BIT]) begin
      r_ovf <= 1'b1;
    end else if (i_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  uart_avalon_host_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .DLOG  (DLOG)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (w_rdDone),
    .i_pushData (w_pushData),
    .i_pop      (w_pop),
    .o_headData (w_headData),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

`ifdef UART_AVALON_HOST_CNT_EN
  logic [15:0] r_cntTx;
  logic [15:0] r_cntRx;

  // Free-running tallies of completed writes and reads, wrapping at 16 bits
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cntTx <= '0;
      r_cntRx <= '0;
    end else begin
      if (w_wrDone) begin
        r_cntTx <= r_cntTx + 16'd1;
      end
      if (w_rdDone) begin
        r_cntRx <= r_cntRx + 16'd1;
      end
    end
  end

  assign o_cnt_tx = r_cntTx;
  assign o_cnt_rx = r_cntRx;
`endif

endmodule

// File: tb/tb_uart_avalon_host.sv
// Self-checking bench for uart_avalon_host: directed scenarios followed by a
// randomized phase scored against a queue-based model of the host.
module tb_uart_avalon_host;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        txValid = 1'b0;
  logic [7:0]  txData = '0;
  logic        txReady;
  logic        rxValid;
  logic [7:0]  rxData;
  logic        rxPar;
  logic        rxReady = 1'b0;
  logic        uartIrq = 1'b0;
  logic        avmRead;
  logic        avmWrite;
  logic [31:0] avmWritedata;
  logic [31:0] avmReaddata = '0;
  logic        avmWait = 1'b0;
  logic        ovf;
  logic        ovfClr = 1'b0;
`ifdef UART_AVALON_HOST_CNT_EN
  logic [15:0] cntTx;
  logic [15:0] cntRx;
`endif

  int checkCount = 0;
  int errorCount = 0;

  uart_avalon_host #(
    .ADW      (32),
    .BYTESIZE (8),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_tx_valid        (txValid),
    .i_tx_data         (txData),
    .o_tx_ready        (txReady),
    .o_rx_valid        (rxValid),
    .o_rx_data         (rxData),
    .o_rx_par          (rxPar),
    .i_rx_ready        (rxReady),
    .i_uart_irq        (uartIrq),
    .o_avm_read        (avmRead),
    .o_avm_write       (avmWrite),
    .o_avm_writedata   (avmWritedata),
    .i_avm_readdata    (avmReaddata),
    .i_avm_waitrequest (avmWait),
    .o_ovf             (ovf),
    .i_ovf_clr         (ovfClr)
`ifdef UART_AVALON_HOST_CNT_EN
    ,
    .o_cnt_tx          (cntTx),
    .o_cnt_rx          (cntRx)
`endif
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the observed value differs
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle's inputs just after the falling edge and lets combinational outputs settle
  task automatic applyStimulus(input logic tv, input logic [7:0] td, input logic irq, input logic wr,
                               input logic [31:0] rd, input logic rr, input logic oc);
    @(negedge clk);
    txValid     = tv;
    txData      = td;
    uartIrq     = irq;
    avmWait     = wr;
    avmReaddata = rd;
    rxReady     = rr;
    ovfClr      = oc;
    #1;
  endtask

  // Reference model state for the randomized phase
  logic [8:0]  rxQ[$];
  logic [7:0]  wrQ[$];
  logic        modelOvf;
  logic        prevDone;
  logic        prevWrite;
  logic [31:0] prevWdata;
  int          modelCntTx;
  int          modelCntRx;

  initial begin
    int nReads;
    bit seen;
    logic [31:0] rd;
    logic rdDone, wrDone;

    // Reset: tx_ready stays low while rst is high, then everything idles at zero
    rst = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("rst_tx_ready", txReady, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("rst_read", avmRead, 1'b0);
    checkOutput("rst_write", avmWrite, 1'b0);
    checkOutput("rst_wdata", avmWritedata, 32'h0);
    checkOutput("rst_rx_valid", rxValid, 1'b0);
    checkOutput("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    // Single write, no wait states
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("w1_tx_ready", txReady, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("w1_write", avmWrite, 1'b1);
    checkOutput("w1_wdata", avmWritedata, 32'h000000A5);
    checkOutput("w1_tx_ready_low", txReady, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("w1_write_end", avmWrite, 1'b0);

    // Write stalled five cycles; a second byte waits for the return to IDLE
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    checkOutput("w2_tx_ready", txReady, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 8'hC3, 1'b0, (k < 6), 32'h0, 1'b0, 1'b0);
      checkOutput("w2_write_held", avmWrite, 1'b1);
      checkOutput("w2_wdata_held", avmWritedata, 32'h0000003C);
      checkOutput("w2_tx_blocked", txReady, 1'b0);
    end
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("w2_write_end", avmWrite, 1'b0);
    checkOutput("w2_second_ready", txReady, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("w2_second_write", avmWrite, 1'b1);
    checkOutput("w2_second_wdata", avmWritedata, 32'h000000C3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("w2_second_end", avmWrite, 1'b0);

    // Single read with parity set
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h80000142, 1'b0, 1'b0);
    checkOutput("r1_read_pre", avmRead, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h80000142, 1'b0, 1'b0);
    checkOutput("r1_read", avmRead, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("r1_read_end", avmRead, 1'b0);
    checkOutput("r1_rx_valid", rxValid, 1'b1);
    checkOutput("r1_rx_data", rxData, 8'h42);
    checkOutput("r1_rx_par", rxPar, 1'b1);
    checkOutput("r1_ovf", ovf, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("r1_popped", rxValid, 1'b0);

    // FIFO fills to DEPTH and blocks further reads until a pop
    nReads = 0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h10 + nReads, 1'b0, 1'b0);
      if (avmRead) nReads++;
    end
    checkOutput("full_reads", nReads, DEPTH);
    checkOutput("full_rx_valid", rxValid, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h14, 1'b1, 1'b0);
    checkOutput("full_head", rxData, 8'h10);
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h14, 1'b0, 1'b0);
      if (avmRead) seen = 1'b1;
    end
    checkOutput("full_resume_read", seen, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("full_drain_valid", rxValid, 1'b1);
      checkOutput("full_drain_data", rxData, 8'h11 + k);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("full_drained", rxValid, 1'b0);

    // Overrun flag: set, hold, clear, then set and clear together
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h40000077, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h40000077, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("ovf_set", ovf, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("ovf_hold", ovf, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("ovf_cleared", ovf, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h40000088, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h40000088, 1'b0, 1'b1);
    checkOutput("ovf_both_read", avmRead, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("ovf_set_wins", ovf, 1'b1);
    checkOutput("ovf_rx_first", rxData, 8'h77);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("ovf_rx_second", rxData, 8'h88);
    checkOutput("ovf_rx_par", rxPar, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("ovf_rx_empty", rxValid, 1'b0);

    // Read wins arbitration over a pending write; reset then aborts the stalled write
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 32'h00000033, 1'b0, 1'b0);
    checkOutput("arb_tx_blocked", txReady, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 32'h00000033, 1'b0, 1'b0);
    checkOutput("arb_read_first", avmRead, 1'b1);
    checkOutput("arb_no_write", avmWrite, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    checkOutput("arb_gap", avmRead | avmWrite, 1'b0);
    checkOutput("arb_tx_ready", txReady, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    checkOutput("arb_write", avmWrite, 1'b1);
    checkOutput("arb_wdata", avmWritedata, 32'h0000005A);
    checkOutput("arb_rx_valid", rxValid, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    checkOutput("abort_write", avmWrite, 1'b0);
    checkOutput("abort_fifo", rxValid, 1'b0);
    rst = 1'b0;

    // Randomized phase against the behavioural model
    modelOvf   = 1'b0;
    prevDone   = 1'b0;
    prevWrite  = 1'b0;
    prevWdata  = '0;
    modelCntTx = 0;
    modelCntRx = 0;
    rxQ.delete();
    wrQ.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rd = $urandom;
      rd[30] = ($urandom_range(0, 7) == 0);
      applyStimulus($urandom_range(0, 1), 8'($urandom), ($urandom_range(0, 7) < 3),
                    $urandom_range(0, 1), rd, $urandom_range(0, 1), ($urandom_range(0, 9) == 0));
      rdDone = avmRead & ~avmWait;
      wrDone = avmWrite & ~avmWait;

      checkOutput("rnd_rw_excl", avmRead & avmWrite, 1'b0);
      checkOutput("rnd_rx_valid", rxValid, rxQ.size() != 0);
      if (rxQ.size() != 0) begin
        checkOutput("rnd_rx_data", rxData, rxQ[0][7:0]);
        checkOutput("rnd_rx_par", rxPar, rxQ[0][8]);
      end
      checkOutput("rnd_ovf", ovf, modelOvf);
      if (txReady) checkOutput("rnd_ready_idle", avmRead | avmWrite, 1'b0);
      if (prevDone) checkOutput("rnd_idle_gap", avmRead | avmWrite, 1'b0);
      if (avmWrite && prevWrite && !prevDone) checkOutput("rnd_wdata_stable", avmWritedata, prevWdata);
`ifdef UART_AVALON_HOST_CNT_EN
      checkOutput("rnd_cnt_tx", cntTx, modelCntTx[15:0]);
      checkOutput("rnd_cnt_rx", cntRx, modelCntRx[15:0]);
`endif

      if (wrDone) begin
        checkOutput("rnd_wr_pending", wrQ.size() != 0, 1'b1);
        if (wrQ.size() != 0) begin
          checkOutput("rnd_wdata", avmWritedata, {24'h0, wrQ.pop_front()});
        end
        modelCntTx++;
      end
      if (rxReady && rxQ.size() != 0) begin
        void'(rxQ.pop_front());
      end
      if (rdDone) begin
        checkOutput("rnd_rd_room", rxQ.size() < DEPTH, 1'b1);
        rxQ.push_back({avmReaddata[8], avmReaddata[7:0]});
        modelCntRx++;
      end
      if (rdDone && avmReaddata[30]) modelOvf = 1'b1;
      else if (ovfClr) modelOvf = 1'b0;
      if (txValid && txReady) wrQ.push_back(txData);

      prevDone  = rdDone | wrDone;
      prevWrite = avmWrite;
      prevWdata = avmWritedata;
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
